uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte producers.
- Sits between the producers and the uart instance.
- Drives the uart's Tx_EN, Tx_WR and Tx_DATA inputs; watches Tx_BUSY to sequence one byte at a time.
- Each producer gets a one-cycle acknowledge when the UART has accepted its byte.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- WR_TIMEOUT, 1023: cycles Tx_WR may stay high without Tx_BUSY rising before the write is aborted (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sched_en  input  1  scheduler enable; low = no new grants.
- req  input  NUM_REQ  per-requester "byte pending", held until ack.
- req_data  input  NUM_REQ*8  flattened bytes; requester i uses bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse: requester i's byte accepted by the UART.
- grant_id  output  3  index of the current or last granted requester.
- sched_busy  output  1  high whenever state is not IDLE.
- Tx_BUSY  input  1  from uart.
- Tx_EN  output  1  to uart; registered copy of sched_en.
- Tx_WR  output  1  to uart; write strobe.
- Tx_DATA  output  8  to uart; latched byte.
- tx_timeout  output  1  one-cycle pulse on an aborted write (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: ack=0, grant_id=0, sched_busy=0, Tx_EN=0, Tx_WR=0, Tx_DATA=8'h00, tx_timeout=0, rr_ptr=0, state=IDLE.
- Reset mid-transfer returns to IDLE immediately. It does not wait for Tx_BUSY.
- FSM states: IDLE, WRITE, WAIT_DONE.
- IDLE:
  - Grants when sched_en=1, Tx_EN=1, Tx_BUSY=0 and req!=0.
  - Picks the first set req bit searching upward from rr_ptr, with wrap-around.
  - Latches that requester's byte into Tx_DATA and its index into grant_id.
  - Asserts Tx_WR and moves to WRITE, all in the same clock edge.
  - Grant decision and Tx_WR rise share one edge: 1-cycle latency from req to Tx_WR.
- WRITE:
  - Tx_WR stays high until Tx_BUSY is sampled 1.
  - On that edge: Tx_WR<=0, ack[grant_id]<=1 for one cycle, rr_ptr<=grant_id+1 (wraps to 0 past NUM_REQ-1), go to WAIT_DONE.
- WAIT_DONE:
  - Waits for Tx_BUSY=0, then returns to IDLE.
  - No grant is issued in the same cycle as the return. Minimum one IDLE cycle between bytes.
- Requester rules:
  - req and data must be held stable until ack.
  - Dropping req after grant does not cancel the write. Its byte is still sent and acked.
  - After ack the requester may re-raise req the next cycle. It then waits behind the others (round robin).
- sched_en falling:
  - The in-flight byte completes.
  - No further grants are made.
  - Tx_EN falls one cycle after sched_en, but only while in IDLE. While busy it is held high until the return to IDLE.
- Fairness: with all req high continuously, grants are strictly cyclic 0,1,..,NUM_REQ-1,0,...
- Tx_DATA only changes on a grant. It holds its value otherwise.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - An 10-bit counter runs in WRITE.
  - If Tx_BUSY has not risen when the counter reaches WR_TIMEOUT: drop Tx_WR, pulse tx_timeout for 1 cycle, give no ack, leave rr_ptr unchanged, return to IDLE.
  - The same requester is therefore retried first.
- Undefined:
  - No counter; WRITE waits indefinitely.
  - tx_timeout is constant 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: localparams S_IDLE=2'd0, S_WRITE=2'd1, S_WAIT_DONE=2'd2.
  - Data width constant UART_DW=8.
  - Default timeout constant.
- One natural sub-module: rr_arbiter.
  - Combinational priority search from rr_ptr with wrap.
  - Outputs a one-hot grant and an encoded index.
  - Reusable by the receive-side distributor.

Test Plan:
1. Single requester, mem-style bytes: req=2'b01, req_data[7:0]=8'hAA; UART model raises Tx_BUSY 3 cycles after Tx_WR and holds it 100 cycles -> Tx_WR high exactly 3 cycles, Tx_DATA=8'hAA, ack=2'b01 for 1 cycle, sched_busy low only after Tx_BUSY falls.
2. Contention: both req high, data 8'h55 and 8'hCC, held after each ack for 6 bytes -> Tx_DATA sequence 55,CC,55,CC,55,CC; acks alternate 01,10.
3. Wrap-around with NUM_REQ=4, req=4'b1001, rr_ptr starting at 1 -> grant order 3,0,3,0.
4. Reset asserted while in WAIT_DONE with Tx_BUSY=1 -> next cycle: state IDLE, Tx_WR=0, Tx_EN=0, ack=0; no grant until reset is released and Tx_BUSY=0.
5. sched_en dropped during WRITE -> current byte is acked, Tx_EN falls after return to IDLE, req remains pending and ungranted.
6. (UART_TX_SCHED_TIMEOUT_EN, WR_TIMEOUT=16) Tx_BUSY stuck 0 -> Tx_WR drops after 16 cycles, tx_timeout pulses once, no ack; the same requester is re-granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// data width and the default write-timeout length.
// Optional feature macro used by the scheduler: UART_TX_SCHED_TIMEOUT_EN.
package uart_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    localparam int UART_DW        = 8;
    localparam int WR_TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        ST_IDLE      = S_IDLE,
        ST_WRITE     = S_WRITE,
        ST_WAIT_DONE = S_WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bus between the byte producers / UART and the transmit scheduler.
//
// Handshake: req[i] acts as "valid" for byte req_data[8i+7:8i]; the producer
// holds both stable until ack[i] pulses for one cycle, which is the single
// "accepted" event (there is no separate ready level). On the UART side,
// Tx_WR is held high until Tx_BUSY is sampled high, which is the UART's
// acceptance of Tx_DATA.
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();

    logic                     sched_en;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*UART_DW-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [2:0]               grant_id;
    logic                     sched_busy;
    logic                     Tx_BUSY;
    logic                     Tx_EN;
    logic                     Tx_WR;
    logic [UART_DW-1:0]       Tx_DATA;
    logic                     tx_timeout;

    // Producers plus UART status: drive the scheduler's inputs.
    modport master (
        output sched_en, req, req_data, Tx_BUSY,
        input  ack, grant_id, sched_busy, Tx_EN, Tx_WR, Tx_DATA, tx_timeout
    );

    // The scheduler itself.
    modport slave (
        input  sched_en, req, req_data, Tx_BUSY,
        output ack, grant_id, sched_busy, Tx_EN, Tx_WR, Tx_DATA, tx_timeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i with
// wrap-around and returns the first set request as one-hot and as an index.
// ptr_i is expected to be below NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [2:0]         gnt_idx_o,
    output logic               gnt_valid_o
);

    logic [3:0] pos_w;
    logic       found;

    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos_w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_w = {1'b0, ptr_i} + 4'(i);
            if (pos_w >= 4'(NUM_REQ)) begin
                pos_w = pos_w - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (pos_w == 4'(j)) && req_i[j]) begin
                    found       = 1'b1;
                    gnt_oh_o[j] = 1'b1;
                    gnt_idx_o   = 3'(j);
                end
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. One byte in flight at a time: grant -> Tx_WR until the UART
// raises Tx_BUSY -> ack the producer -> wait for Tx_BUSY to fall.
// Optional macro UART_TX_SCHED_TIMEOUT_EN: abort a write whose Tx_BUSY never
// rises within WR_TIMEOUT cycles (tx_timeout pulse, no ack, same requester
// retried first). Without it, WRITE waits indefinitely and tx_timeout is 0.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WR_TIMEOUT = WR_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_scheduler_if.slave  bus,
    output logic [1:0]          dbg_state_o
);

    sched_state_t         state_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   ack_d;
    logic [2:0]           grant_id_q;
    logic [2:0]           rr_ptr_q;
    logic [2:0]           rr_ptr_d;
    logic                 sched_busy_q;
    logic                 tx_en_q;
    logic                 tx_wr_q;
    logic [UART_DW-1:0]   tx_data_q;
    logic [UART_DW-1:0]   tx_data_d;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [2:0]           gnt_idx;
    logic                 gnt_valid;
    logic                 grant_ok;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(WR_TIMEOUT - 1);
    logic [9:0]           to_cnt_q;
    logic                 tx_timeout_q;
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = ^10'(WR_TIMEOUT);
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (bus.req),
        .ptr_i       (rr_ptr_q),
        .gnt_oh_o    (gnt_oh),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Select the winning requester's byte for latching into Tx_DATA.
    always_comb begin
        tx_data_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                tx_data_d = bus.req_data[i*UART_DW +: UART_DW];
            end
        end
    end

    // Ack vector for the granted requester and the pointer just past it.
    always_comb begin
        ack_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (grant_id_q == 3'(i));
        end
        rr_ptr_d = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
    end

    // A grant needs the scheduler enabled, the UART enabled and idle, and a request.
    assign grant_ok = bus.sched_en & tx_en_q & ~bus.Tx_BUSY & gnt_valid;

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ack_q        <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            sched_busy_q <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            tx_timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // Tx_EN only follows sched_en here, so a transfer is never cut off.
                    tx_en_q <= bus.sched_en;
                    if (grant_ok) begin
                        tx_data_q    <= tx_data_d;
                        grant_id_q   <= gnt_idx;
                        tx_wr_q      <= 1'b1;
                        sched_busy_q <= 1'b1;
                        state_q      <= ST_WRITE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (bus.Tx_BUSY) begin
                        tx_wr_q  <= 1'b0;
                        ack_q    <= ack_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_WAIT_DONE;
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        // Abort: rr_ptr stays put so this requester goes first again.
                        tx_wr_q      <= 1'b0;
                        tx_timeout_q <= 1'b1;
                        sched_busy_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 10'd1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!bus.Tx_BUSY) begin
                        sched_busy_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.sched_busy = sched_busy_q;
    assign bus.Tx_EN      = tx_en_q;
    assign bus.Tx_WR      = tx_wr_q;
    assign bus.Tx_DATA    = tx_data_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign bus.tx_timeout = tx_timeout_q;
`else
    assign bus.tx_timeout = 1'b0;
`endif
    assign dbg_state_o    = state_q;

endmodule
